// File: rtl/fifo_pkt_reader.sv
// Drains length-prefixed packets from a registered-read byte FIFO onto a valid/ready egress port.
// Drops packets whose length byte exceeds MAX_LEN and counts forwarded and dropped packets.
module fifo_pkt_reader #(
  parameter int unsigned W_WIDTH = 8,
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  input  logic [W_WIDTH-1:0] fifo_data,
  output logic               port_valid,
  input  logic               port_ready,
  output logic [W_WIDTH-1:0] port_data,
  output logic               port_sop,
  output logic               port_eop,
  output logic               drop_pulse,
  output logic [CNT_W-1:0]   pkt_cnt,
  output logic [CNT_W-1:0]   drop_cnt
);

  typedef enum logic [1:0] {StHdr, StPay, StDrop} state_e;

  typedef struct packed {
    logic [W_WIDTH-1:0] data;
    logic               sop;
    logic               eop;
  } entry_t;

  localparam logic [W_WIDTH-1:0] MaxLen = W_WIDTH'(MAX_LEN);

  state_e             state;
  logic [W_WIDTH-1:0] rem;
  logic               inflight;
  logic [1:0]         occ;
  entry_t             head;
  entry_t             tail;

  logic               pop;
  logic               push;
  logic               drop;
  entry_t             new_entry;
  logic [2:0]         room_used;

  // Occupancy is taken net of this cycle's pop so a full-rate stream keeps reading every cycle.
  assign pop        = port_valid & port_ready;
  assign room_used  = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign fifo_rd_en = !rst && !fifo_empty && (room_used < 3'd2);

  assign port_valid = (occ != 2'd0);
  assign port_data  = head.data;
  assign port_sop   = head.sop;
  assign port_eop   = head.eop;

  always_comb begin
    push      = 1'b0;
    drop      = 1'b0;
    new_entry = '{data: fifo_data, sop: 1'b0, eop: 1'b0};
    if (inflight) begin
      case (state)
        StHdr: begin
          if (fifo_data > MaxLen) begin
            drop = 1'b1;
          end else begin
            push          = 1'b1;
            new_entry.sop = 1'b1;
            new_entry.eop = (fifo_data == '0);
          end
        end
        StPay: begin
          push          = 1'b1;
          new_entry.eop = (rem == W_WIDTH'(1));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= StHdr;
      rem   <= '0;
    end else if (inflight) begin
      case (state)
        StHdr: begin
          if (fifo_data > MaxLen) begin
            state <= StDrop;
            rem   <= fifo_data;
          end else if (fifo_data != '0) begin
            state <= StPay;
            rem   <= fifo_data;
          end
        end
        StPay, StDrop: begin
          rem <= rem - W_WIDTH'(1);
          if (rem == W_WIDTH'(1)) state <= StHdr;
        end
        default: state <= StHdr;
      endcase
    end
  end

  // Two-entry skid buffer: head drives the port, tail only fills while head is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      occ      <= 2'd0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= fifo_rd_en;
      occ      <= occ + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        if (occ == 2'd2) begin
          head <= tail;
          if (push) tail <= new_entry;
        end else if (push) begin
          head <= new_entry;
        end
      end else if (push) begin
        if (occ == 2'd0) head <= new_entry;
        else             tail <= new_entry;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_pulse <= 1'b0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      drop_pulse <= drop;
      if (drop)            drop_cnt <= drop_cnt + CNT_W'(1);
      if (pop && head.eop) pkt_cnt  <= pkt_cnt + CNT_W'(1);
    end
  end

endmodule
